phys_reg_free_list: RTL and testbench

PHYS_REG_FREE_LIST -- requirements
Module: phys_reg_free_list

---
 rtl/phys_reg_free_list.sv | 70 +++++++
 tb/tb_phys_reg_free_list.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_free_list.sv
// Physical register free list: 32-entry circular tag buffer with speculative and committed read pointers.
// Zero-latency combinational allocation; take is ignored when empty, and release is refused when the committed list is full.
module phys_reg_free_list (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       take,
  input  logic       commitAlloc,
  input  logic       releaseReq,
  input  logic [5:0] releaseTag,
  input  logic       rewind,
  output logic [5:0] allocTag,
  output logic       allocValid,
  output logic       reserve,
  output logic [5:0] selectReserve,
  output logic [5:0] freeCount,
  output logic       error
);

  logic [5:0] mem [32];
  logic [5:0] rdPtr, cmPtr, wrPtr;
  logic [5:0] occupancy;
  logic       take_ok, commit_ok, commit_bad, release_ok, release_bad;

  assign freeCount     = wrPtr - rdPtr;
  assign occupancy     = wrPtr - cmPtr;
  assign allocTag      = mem[rdPtr[4:0]];
  assign allocValid    = (freeCount != 6'd0) && !rewind;
  assign reserve       = take && allocValid && en;
  assign selectReserve = allocTag;

  assign take_ok    = reserve;
  assign commit_ok  = en && commitAlloc && (cmPtr != rdPtr);
  assign commit_bad = en && commitAlloc && (cmPtr == rdPtr);

  // When the list is completely free, a same-cycle take consumes the slot that the release overwrites.
  // The release is therefore allowed through even though committed occupancy is at 32.
  assign release_ok  = en && releaseReq && (releaseTag != 6'd0) &&
                       ((occupancy < 6'd32) || ((freeCount == 6'd32) && take_ok));
  assign release_bad = en && releaseReq && (releaseTag != 6'd0) && !release_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= 6'(32 + i);
      end
      rdPtr <= 6'd0;
      cmPtr <= 6'd0;
      wrPtr <= 6'd32;
      error <= 1'b0;
    end else begin
      if (release_ok) begin
        mem[wrPtr[4:0]] <= releaseTag;
        wrPtr           <= wrPtr + 6'd1;
      end
      if (commit_ok) begin
        cmPtr <= cmPtr + 6'd1;
      end
      if (en && rewind) begin
        rdPtr <= commit_ok ? cmPtr + 6'd1 : cmPtr;
      end else if (take_ok) begin
        rdPtr <= rdPtr + 6'd1;
      end
      if (commit_bad || release_bad) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: inputs change on the falling edge, outputs are sampled 1 time unit later.
module tb_phys_reg_free_list;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, take, commitAlloc, releaseReq, rewind;
  logic [5:0] releaseTag;
  logic [5:0] allocTag, selectReserve, freeCount;
  logic       allocValid, reserve, error;

  int checks = 0;
  int errors = 0;

  phys_reg_free_list dut (
    .clk(clk), .reset(reset), .en(en), .take(take), .commitAlloc(commitAlloc),
    .releaseReq(releaseReq), .releaseTag(releaseTag), .rewind(rewind),
    .allocTag(allocTag), .allocValid(allocValid), .reserve(reserve),
    .selectReserve(selectReserve), .freeCount(freeCount), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic idle();
    en = 1'b1; take = 1'b0; commitAlloc = 1'b0; releaseReq = 1'b0; releaseTag = 6'd0; rewind = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    take  = 1'b1;
    reset = 1'b1;
    #1;
    checks++; if (allocTag !== 6'd32) begin errors++; $display("FAIL reset_allocTag got %0d expected 32", allocTag); end
    checks++; if (allocValid !== 1'b1) begin errors++; $display("FAIL reset_allocValid got %0b expected 1", allocValid); end
    checks++; if (freeCount !== 6'd32) begin errors++; $display("FAIL reset_freeCount got %0d expected 32", freeCount); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %0b expected 0", error); end
    checks++; if (reserve !== 1'b1) begin errors++; $display("FAIL reset_reserve got %0b expected 1", reserve); end
    checks++; if (selectReserve !== 6'd32) begin errors++; $display("FAIL reset_selectReserve got %0d expected 32", selectReserve); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    take = 1'b0;
    #1;
    checks++; if (freeCount !== 6'd29) begin errors++; $display("FAIL pre_midreset_freeCount got %0d expected 29", freeCount); end
    // A mid-operation reset wins over rewind, commit, release and take.
    rewind = 1'b1; commitAlloc = 1'b1; releaseReq = 1'b1; releaseTag = 6'd9; take = 1'b1;
    reset = 1'b1;
    #1;
    checks++; if (freeCount !== 6'd32) begin errors++; $display("FAIL midreset_async_freeCount got %0d expected 32", freeCount); end
    checks++; if (allocTag !== 6'd32) begin errors++; $display("FAIL midreset_async_allocTag got %0d expected 32", allocTag); end
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    checks++; if (freeCount !== 6'd32) begin errors++; $display("FAIL midreset_freeCount got %0d expected 32", freeCount); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL midreset_error got %0b expected 0", error); end
  endtask

  task automatic test_drain();
    do_reset();
    take = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      checks++; if (reserve !== 1'b1) begin errors++; $display("FAIL drain_reserve[%0d] got %0b expected 1", i, reserve); end
      checks++; if (selectReserve !== 6'(32 + i)) begin errors++; $display("FAIL drain_tag[%0d] got %0d expected %0d", i, selectReserve, 32 + i); end
      @(negedge clk);
    end
    #1;
    checks++; if (reserve !== 1'b0) begin errors++; $display("FAIL empty_reserve got %0b expected 0", reserve); end
    checks++; if (allocValid !== 1'b0) begin errors++; $display("FAIL empty_allocValid got %0b expected 0", allocValid); end
    checks++; if (freeCount !== 6'd0) begin errors++; $display("FAIL empty_freeCount got %0d expected 0", freeCount); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (freeCount !== 6'd0) begin errors++; $display("FAIL empty_take_freeCount got %0d expected 0", freeCount); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL empty_take_error got %0b expected 0", error); end
  endtask

  task automatic test_rewind();
    do_reset();
    take = 1'b1;
    repeat (3) @(negedge clk);
    take = 1'b0; commitAlloc = 1'b1;
    @(negedge clk);
    commitAlloc = 1'b0; rewind = 1'b1; take = 1'b1;
    #1;
    checks++; if (allocValid !== 1'b0) begin errors++; $display("FAIL rewind_allocValid got %0b expected 0", allocValid); end
    checks++; if (reserve !== 1'b0) begin errors++; $display("FAIL rewind_reserve got %0b expected 0", reserve); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (allocTag !== 6'd33) begin errors++; $display("FAIL rewind_allocTag got %0d expected 33", allocTag); end
    checks++; if (freeCount !== 6'd31) begin errors++; $display("FAIL rewind_freeCount got %0d expected 31", freeCount); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rewind_error got %0b expected 0", error); end
    // Rewind and a legal commit in the same cycle restore to the advanced committed pointer.
    do_reset();
    take = 1'b1;
    repeat (3) @(negedge clk);
    take = 1'b0; rewind = 1'b1; commitAlloc = 1'b1;
    @(negedge clk);
    idle();
    #1;
    checks++; if (allocTag !== 6'd33) begin errors++; $display("FAIL rewind_commit_allocTag got %0d expected 33", allocTag); end
    checks++; if (freeCount !== 6'd31) begin errors++; $display("FAIL rewind_commit_freeCount got %0d expected 31", freeCount); end
  endtask

  task automatic test_empty_release();
    do_reset();
    take = 1'b1;
    repeat (32) @(negedge clk);
    take = 1'b0; commitAlloc = 1'b1;
    repeat (32) @(negedge clk);
    idle();
    #1;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL commit32_error got %0b expected 0", error); end
    take = 1'b1; releaseReq = 1'b1; releaseTag = 6'd5;
    #1;
    checks++; if (reserve !== 1'b0) begin errors++; $display("FAIL empty_release_reserve got %0b expected 0", reserve); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (allocTag !== 6'd5) begin errors++; $display("FAIL empty_release_allocTag got %0d expected 5", allocTag); end
    checks++; if (freeCount !== 6'd1) begin errors++; $display("FAIL empty_release_freeCount got %0d expected 1", freeCount); end
  endtask

  task automatic test_release_rules();
    // Continues from the single-entry state left by test_empty_release.
    releaseReq = 1'b1; releaseTag = 6'd0;
    @(negedge clk);
    idle();
    #1;
    checks++; if (freeCount !== 6'd1) begin errors++; $display("FAIL release_p0_freeCount got %0d expected 1", freeCount); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL release_p0_error got %0b expected 0", error); end
    do_reset();
    releaseReq = 1'b1; releaseTag = 6'd7;
    @(negedge clk);
    idle();
    #1;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL release_full_error got %0b expected 1", error); end
    checks++; if (freeCount !== 6'd32) begin errors++; $display("FAIL release_full_freeCount got %0d expected 32", freeCount); end
    take = 1'b1;
    repeat (3) @(negedge clk);
    idle();
    #1;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL error_sticky got %0b expected 1", error); end
    do_reset();
    commitAlloc = 1'b1;
    @(negedge clk);
    idle();
    #1;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL commit_underflow_error got %0b expected 1", error); end
  endtask

  task automatic test_full_take_release();
    do_reset();
    take = 1'b1; releaseReq = 1'b1; releaseTag = 6'd9;
    #1;
    checks++; if (reserve !== 1'b1) begin errors++; $display("FAIL full_tr_reserve got %0b expected 1", reserve); end
    checks++; if (selectReserve !== 6'd32) begin errors++; $display("FAIL full_tr_tag got %0d expected 32", selectReserve); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (freeCount !== 6'd32) begin errors++; $display("FAIL full_tr_freeCount got %0d expected 32", freeCount); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL full_tr_error got %0b expected 0", error); end
    take = 1'b1;
    repeat (31) @(negedge clk);
    idle();
    #1;
    checks++; if (allocTag !== 6'd9) begin errors++; $display("FAIL full_tr_wrapTag got %0d expected 9", allocTag); end
    checks++; if (freeCount !== 6'd1) begin errors++; $display("FAIL full_tr_lastCount got %0d expected 1", freeCount); end
  endtask

  task automatic test_wrap();
    logic [5:0] q[$];
    do_reset();
    for (int i = 0; i < 32; i++) q.push_back(6'(32 + i));
    take = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) void'(q.pop_front());
    take = 1'b0; commitAlloc = 1'b1;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      take = 1'b1; releaseReq = 1'b1; releaseTag = 6'(k + 1); commitAlloc = (k > 0);
      #1;
      checks++; if (reserve !== 1'b1) begin errors++; $display("FAIL wrap_reserve[%0d] got %0b expected 1", k, reserve); end
      checks++; if (selectReserve !== q[0]) begin errors++; $display("FAIL wrap_tag[%0d] got %0d expected %0d", k, selectReserve, q[0]); end
      void'(q.pop_front());
      q.push_back(6'(k + 1));
      @(negedge clk);
      #1;
      checks++; if (int'(freeCount) !== q.size() || freeCount > 6'd32) begin errors++; $display("FAIL wrap_freeCount[%0d] got %0d expected %0d", k, freeCount, q.size()); end
    end
    idle();
    #1;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL wrap_error got %0b expected 0", error); end
  endtask

  task automatic test_enable();
    do_reset();
    take = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b0; take = 1'b1; releaseReq = 1'b1; releaseTag = 6'd9; rewind = 1'b1; commitAlloc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (reserve !== 1'b0) begin errors++; $display("FAIL en0_reserve[%0d] got %0b expected 0", i, reserve); end
      @(negedge clk);
    end
    idle();
    #1;
    checks++; if (freeCount !== 6'd30) begin errors++; $display("FAIL en0_freeCount got %0d expected 30", freeCount); end
    checks++; if (allocTag !== 6'd34) begin errors++; $display("FAIL en0_allocTag got %0d expected 34", allocTag); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL en0_error got %0b expected 0", error); end
    rewind = 1'b1;
    @(negedge clk);
    idle();
    #1;
    checks++; if (allocTag !== 6'd32) begin errors++; $display("FAIL en0_cmPtr_allocTag got %0d expected 32", allocTag); end
    checks++; if (freeCount !== 6'd32) begin errors++; $display("FAIL en0_cmPtr_freeCount got %0d expected 32", freeCount); end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_drain();
    test_rewind();
    test_empty_release();
    test_release_rules();
    test_full_take_release();
    test_wrap();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
